// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: one outstanding request to a variable-latency memory,
// holds the fetched word for decode, applies redirects and drops stale responses.
module fetch_controller #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'hBFC00000,
    parameter int                    COUNT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trigger,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [DATA_WIDTH-1:0]  redirect_pc,
    output logic                   mem_req,
    output logic [DATA_WIDTH-1:0]  mem_addr,
    input  logic                   mem_rvalid,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    output logic [DATA_WIDTH-1:0]  instr,
    output logic                   instr_valid,
    output logic [DATA_WIDTH-1:0]  pc_out,
    output logic [COUNT_WIDTH-1:0] fetch_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam logic [DATA_WIDTH-1:0]  PC_STEP    = {{(DATA_WIDTH-3){1'b0}}, 3'b100};
    localparam logic [DATA_WIDTH-1:0]  ALIGN_MASK = ~{{(DATA_WIDTH-2){1'b0}}, 2'b11};
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                   state_r, state_s;
    logic [DATA_WIDTH-1:0]    pc_r, pc_s;
    logic [DATA_WIDTH-1:0]    instr_r, instr_s;
    logic                     instr_valid_r, instr_valid_s;
    logic                     kill_r, kill_s;
    logic                     mem_req_r;
    logic [COUNT_WIDTH-1:0]   count_r, count_s;
    logic [DATA_WIDTH-1:0]    target_s;

    assign target_s = redirect_pc & ALIGN_MASK;

    // Next-state and datapath update; trigger=0 overrides redirect and accept everywhere.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        instr_s       = instr_r;
        instr_valid_s = instr_valid_r;
        kill_s        = kill_r;
        count_s       = count_r;
        case (state_r)
            ST_IDLE: begin
                pc_s          = RESET_VECTOR;
                kill_s        = 1'b0;
                instr_valid_s = 1'b0;
                if (trigger) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!trigger) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_WAIT;
                    if (redirect) begin
                        pc_s   = target_s;
                        kill_s = 1'b1;
                    end else begin
                        kill_s = kill_r;
                    end
                end
            end
            ST_WAIT: begin
                if (!trigger) begin
                    state_s = ST_DRAIN;
                end else if (mem_rvalid) begin
                    // A redirect arriving with the response also makes that response stale.
                    if (kill_r || redirect) begin
                        kill_s  = 1'b0;
                        pc_s    = redirect ? target_s : pc_r;
                        state_s = ST_REQ;
                    end else begin
                        instr_s       = mem_rdata;
                        instr_valid_s = 1'b1;
                        state_s       = ST_HOLD;
                    end
                end else if (redirect) begin
                    pc_s   = target_s;
                    kill_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (!trigger) begin
                    instr_valid_s = 1'b0;
                    pc_s          = RESET_VECTOR;
                    kill_s        = 1'b0;
                    state_s       = ST_IDLE;
                end else if (!stall) begin
                    instr_valid_s = 1'b0;
                    count_s       = count_r + COUNT_ONE;
                    pc_s          = redirect ? target_s : (pc_r + PC_STEP);
                    state_s       = ST_REQ;
                end else if (redirect) begin
                    instr_valid_s = 1'b0;
                    pc_s          = target_s;
                    state_s       = ST_REQ;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (mem_rvalid) begin
                    pc_s    = RESET_VECTOR;
                    kill_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s       = ST_IDLE;
                pc_s          = RESET_VECTOR;
                instr_valid_s = 1'b0;
                kill_s        = 1'b0;
            end
        endcase
    end

    // State and datapath registers; mem_req is registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_VECTOR;
            instr_r       <= {DATA_WIDTH{1'b0}};
            instr_valid_r <= 1'b0;
            kill_r        <= 1'b0;
            mem_req_r     <= 1'b0;
            count_r       <= {COUNT_WIDTH{1'b0}};
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            instr_r       <= instr_s;
            instr_valid_r <= instr_valid_s;
            kill_r        <= kill_s;
            mem_req_r     <= (state_s == ST_REQ);
            count_r       <= count_s;
        end
    end

    assign mem_req     = mem_req_r;
    assign mem_addr    = pc_r;
    assign pc_out      = pc_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign fetch_count = count_r;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus a randomized
// run scored against a transaction-level model of the fetch stream.
module tb_fetch_controller;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trigger = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    // memory responder state
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    int          fixed_lat = 2;
    bit          rand_lat = 1'b0;

    fetch_controller dut (
        .clk(clk), .rst(rst), .trigger(trigger), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .instr(instr), .instr_valid(instr_valid), .pc_out(pc_out),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == RV) return 32'h00500093;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic mem_tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_fn(pend_addr);
            end
        end
        if (mem_req) begin
            pend_cnt  = rand_lat ? int'($urandom_range(1, 4)) : fixed_lat;
            pend_addr = mem_addr;
        end
    endtask

    task automatic step();
        @(negedge clk);
        mem_tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; trigger = 1'b0; stall = 1'b0; redirect = 1'b0;
        mem_rvalid = 1'b0; pend_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %0b want 0", mem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", instr_valid); end
        checks++; if (pc_out !== RV) begin errors++; $display("FAIL reset_pc got %h want %h", pc_out, RV); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instr); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count got %0d want 0", fetch_count); end
    endtask

    task automatic test_boot();
        bit found;
        int n;
        rand_lat = 1'b0; fixed_lat = 2; trigger = 1'b1; stall = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin step(); found = mem_req; end
        checks++; if (!found || mem_addr !== RV) begin errors++; $display("FAIL boot_req found=%0b addr %h want %h", found, mem_addr, RV); end
        found = 1'b0; n = 0;
        for (int i = 0; i < 10 && !found; i++) begin step(); n++; found = instr_valid; end
        checks++; if (!found || n != 3) begin errors++; $display("FAIL boot_latency got %0d cycles want 3", n); end
        checks++; if (instr !== 32'h00500093) begin errors++; $display("FAIL boot_instr got %h want 00500093", instr); end
        checks++; if (pc_out !== RV) begin errors++; $display("FAIL boot_pc got %h want %h", pc_out, RV); end
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hBFC00004) begin errors++; $display("FAIL boot_next req=%0b addr %h want BFC00004", mem_req, mem_addr); end
        checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL boot_count got %0d want 1", fetch_count); end
    endtask

    task automatic test_stall();
        bit found;
        stall = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin step(); found = instr_valid; end
        checks++; if (!found) begin errors++; $display("FAIL stall_wait got no instr_valid want 1"); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (instr_valid !== 1'b1 || instr !== mem_fn(32'hBFC00004) || pc_out !== 32'hBFC00004
                || mem_req !== 1'b0 || fetch_count !== 32'd1) begin
                errors++;
                $display("FAIL stall_hold v=%0b instr %h pc %h req %0b cnt %0d want 1 %h BFC00004 0 1",
                         instr_valid, instr, pc_out, mem_req, fetch_count, mem_fn(32'hBFC00004));
            end
        end
    endtask

    task automatic test_redirect_accept();
        stall = 1'b0; redirect = 1'b1; redirect_pc = 32'hBFC00103;
        step();
        redirect = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hBFC00100) begin errors++; $display("FAIL redir_accept req=%0b addr %h want BFC00100", mem_req, mem_addr); end
        checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL redir_count got %0d want 2", fetch_count); end
    endtask

    task automatic test_redirect_wait();
        bit found, saw_valid;
        fixed_lat = 3;
        step();
        redirect = 1'b1; redirect_pc = 32'hBFC00200;
        step();
        redirect = 1'b0;
        found = 1'b0; saw_valid = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (instr_valid) saw_valid = 1'b1;
            found = mem_req;
        end
        checks++; if (saw_valid) begin errors++; $display("FAIL wait_discard instr_valid got 1 want 0"); end
        checks++; if (!found || mem_addr !== 32'hBFC00200) begin errors++; $display("FAIL wait_redir found=%0b addr %h want BFC00200", found, mem_addr); end
    endtask

    task automatic test_drain();
        bit seen_req, found;
        step();
        trigger = 1'b0;
        seen_req = 1'b0;
        for (int i = 0; i < 10; i++) begin step(); if (mem_req) seen_req = 1'b1; end
        checks++; if (seen_req) begin errors++; $display("FAIL drain_req got mem_req=1 want 0"); end
        checks++; if (pc_out !== RV || instr_valid !== 1'b0) begin errors++; $display("FAIL drain_idle pc %h v=%0b want %h 0", pc_out, instr_valid, RV); end
        trigger = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin step(); found = mem_req; end
        checks++; if (!found || mem_addr !== RV) begin errors++; $display("FAIL drain_restart found=%0b addr %h want %h", found, mem_addr, RV); end
    endtask

    task automatic test_async_reset();
        bit found, bad;
        stall = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin step(); found = instr_valid; end
        checks++; if (!found) begin errors++; $display("FAIL areset_hold got no instr_valid want 1"); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || pc_out !== RV || fetch_count !== 32'h0) begin
            errors++;
            $display("FAIL areset_clear v=%0b instr %h pc %h cnt %0d want 0 0 %h 0", instr_valid, instr, pc_out, fetch_count, RV);
        end
        rst = 1'b0; pend_cnt = 0; stall = 1'b0;
        // abort an in-flight request, then let its response arrive while idle
        fixed_lat = 4;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin step(); found = mem_req; end
        step();
        #2 rst = 1'b1; trigger = 1'b0;
        #1 rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin step(); if (instr_valid || mem_req) bad = 1'b1; end
        checks++; if (!found || bad) begin errors++; $display("FAIL areset_stale found=%0b activity=%0b want 1 0", found, bad); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, tgt;
        int          exp_count;
        bit          stale, in_flight;
        do_reset();
        rand_lat = 1'b1; trigger = 1'b1;
        exp_pc = RV; exp_count = 0; stale = 1'b0; in_flight = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (mem_req) begin
                checks++; if (mem_addr !== exp_pc) begin errors++; $display("FAIL rnd_addr cyc %0d got %h want %h", cyc, mem_addr, exp_pc); end
                stale = 1'b0; in_flight = 1'b1;
            end
            if (stale) begin
                checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rnd_stale cyc %0d instr_valid got 1 want 0", cyc); end
            end
            if (instr_valid) begin
                checks++;
                if (pc_out !== exp_pc || instr !== mem_fn(exp_pc) || mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_hold cyc %0d pc %h instr %h req %0b want %h %h 0", cyc, pc_out, instr, mem_req, exp_pc, mem_fn(exp_pc));
                end
                in_flight = 1'b0;
            end
            checks++; if (fetch_count !== exp_count) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", cyc, fetch_count, exp_count); end
            mem_tick();
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = (in_flight || instr_valid) && ($urandom_range(0, 4) == 0);
            tgt         = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF0 | $urandom_range(0, 15) : $urandom();
            redirect_pc = tgt;
            if (instr_valid) begin
                if (!stall) begin
                    exp_count++;
                    exp_pc = redirect ? (tgt & 32'hFFFFFFFC) : exp_pc + 32'd4;
                end else if (redirect) begin
                    exp_pc = tgt & 32'hFFFFFFFC;
                end
            end else if (in_flight && redirect) begin
                exp_pc = tgt & 32'hFFFFFFFC;
                stale  = 1'b1;
            end
        end
        redirect = 1'b0;
        checks++; if (exp_count < 100) begin errors++; $display("FAIL rnd_progress accepts %0d want >=100", exp_count); end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_stall();
        test_redirect_accept();
        test_redirect_wait();
        test_drain();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
